// File: rtl/irig_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : irig_pkg
// Description : Shared symbol codes, FSM state encoding and default cycle
//               thresholds for the IRIG-B bit classifier (10 MHz clock).
// Revision    : 1.0 - initial release
// ============================================================================
package irig_pkg;

  // Counter width for high/low pulse measurement
  localparam int CNT_W = 17;

  // Symbol codes presented on sym
  localparam logic [1:0] SYM_D0   = 2'b00;
  localparam logic [1:0] SYM_D1   = 2'b01;
  localparam logic [1:0] SYM_MARK = 2'b10;
  localparam logic [1:0] SYM_ERR  = 2'b11;

  // Default thresholds in 10 MHz cycles
  localparam int DEF_FILTER_LEN = 4;
  localparam int DEF_D0_MIN     = 15000;
  localparam int DEF_D1_MIN     = 35000;
  localparam int DEF_MK_MIN     = 65000;
  localparam int DEF_HI_MAX     = 95000;
  localparam int DEF_LO_TIMEOUT = 120000;

  // Classifier state encoding
  typedef enum logic [1:0] {
    ST_SEEK     = 2'd0,
    ST_LOW      = 2'd1,
    ST_HIGH     = 2'd2,
    ST_STUCK_HI = 2'd3
  } state_t;

  // Map a measured high width onto a symbol code
  function automatic logic [1:0] classify(
    input logic [CNT_W-1:0] n,
    input logic [CNT_W-1:0] d0_min,
    input logic [CNT_W-1:0] d1_min,
    input logic [CNT_W-1:0] mk_min,
    input logic [CNT_W-1:0] hi_max
  );
    logic [1:0] code;
    if (n < d0_min)      code = SYM_ERR;
    else if (n < d1_min) code = SYM_D0;
    else if (n < mk_min) code = SYM_D1;
    else if (n < hi_max) code = SYM_MARK;
    else                 code = SYM_ERR;
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irig_glitch_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : irig_glitch_filter
// Description : 2-FF synchronizer followed by a FILTER_LEN-sample debounce.
//               Emits registered rise/fall strobes in the cycle the filtered
//               level changes.
// Revision    : 1.0 - initial release
// ============================================================================
module irig_glitch_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk_10mhz,
  input  logic rst_n,
  input  logic din_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW     = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] C_LAST = CW'(FILTER_LEN - 1);

  logic          sync1_q, sync2_q;
  logic          filt_q, rise_q, fall_q;
  logic [CW-1:0] cnt_q;

  // Two-stage synchronizer; idles high like an undriven IRIG line
  always_ff @(posedge clk_10mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: flip after FILTER_LEN consecutive samples disagreeing with filt_q
  always_ff @(posedge clk_10mhz or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (sync2_q != filt_q) begin
        if (cnt_q == C_LAST) begin
          filt_q <= sync2_q;
          cnt_q  <= '0;
          rise_q <= sync2_q;
          fall_q <= ~sync2_q;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign filt_o = filt_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule
`default_nettype wire

// File: rtl/irig_bit_classifier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : irig_bit_classifier
// Description : Measures filtered IRIG-B high pulses and classifies them as
//               D0 / D1 / MARK / ERR; tracks loss of signal.
// Revision    : 1.0 - initial release
// ============================================================================
module irig_bit_classifier
  import irig_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN,
  parameter int D0_MIN     = DEF_D0_MIN,
  parameter int D1_MIN     = DEF_D1_MIN,
  parameter int MK_MIN     = DEF_MK_MIN,
  parameter int HI_MAX     = DEF_HI_MAX,
  parameter int LO_TIMEOUT = DEF_LO_TIMEOUT
) (
  input  logic       clk_10mhz,
  input  logic       rst,
  input  logic       irigb,
  output logic       rise_stb,
  output logic       sym_valid,
  output logic [1:0] sym,
  output logic       los
);

  localparam logic [CNT_W-1:0] C_D0_MIN = CNT_W'(D0_MIN);
  localparam logic [CNT_W-1:0] C_D1_MIN = CNT_W'(D1_MIN);
  localparam logic [CNT_W-1:0] C_MK_MIN = CNT_W'(MK_MIN);
  localparam logic [CNT_W-1:0] C_HI_MAX = CNT_W'(HI_MAX);
  localparam logic [CNT_W-1:0] C_LO_TO  = CNT_W'(LO_TIMEOUT);
  localparam logic [CNT_W-1:0] C_SAT    = '1;

  logic             rst_sync_q;
  logic             w_filt, w_rise, w_fall;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             sv_q, sv_d, los_q, los_d;
  logic [1:0]       sym_q, sym_d, w_class;
  logic [CNT_W-1:0] w_hi_inc, w_lo_inc;
  logic             w_hi_top, w_lo_hit;

  // Reset release is retimed so the first active edge is the second clock after deassertion
  always_ff @(posedge clk_10mhz or negedge rst) begin
    if (!rst) rst_sync_q <= 1'b0;
    else      rst_sync_q <= 1'b1;
  end

  irig_glitch_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk_10mhz (clk_10mhz),
    .rst_n     (rst_sync_q),
    .din_i     (irigb),
    .filt_o    (w_filt),
    .rise_o    (w_rise),
    .fall_o    (w_fall)
  );

  // Saturating increments and threshold detection (fire once, on reaching the limit)
  assign w_hi_inc = (hi_q == C_SAT) ? hi_q : hi_q + CNT_W'(1);
  assign w_lo_inc = (lo_q == C_SAT) ? lo_q : lo_q + CNT_W'(1);
  assign w_hi_top = w_filt && (hi_q < C_HI_MAX) && (w_hi_inc >= C_HI_MAX);
  assign w_lo_hit = !w_filt && (lo_q != C_LO_TO) && (w_lo_inc == C_LO_TO);
  assign w_class  = classify(hi_q, C_D0_MIN, C_D1_MIN, C_MK_MIN, C_HI_MAX);

  // State and registered outputs
  always_ff @(posedge clk_10mhz or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q <= ST_SEEK;
      hi_q    <= '0;
      lo_q    <= '0;
      sv_q    <= 1'b0;
      sym_q   <= SYM_ERR;
      los_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sv_q    <= sv_d;
      sym_q   <= sym_d;
      los_q   <= los_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEEK: begin
        if (w_fall)        state_d = ST_LOW;
        else if (w_hi_top) state_d = ST_STUCK_HI;
      end
      ST_LOW: begin
        if (w_rise) state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (w_fall)        state_d = ST_LOW;
        else if (w_hi_top) state_d = ST_STUCK_HI;
      end
      ST_STUCK_HI: begin
        if (w_fall) state_d = ST_LOW;
      end
      default: state_d = ST_SEEK;
    endcase
  end

  // Counters, symbol emission and loss-of-signal flag
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    sv_d  = 1'b0;
    sym_d = sym_q;
    los_d = los_q;
    case (state_q)
      ST_SEEK: begin
        if (w_fall)      hi_d = '0;
        else if (w_filt) hi_d = w_hi_inc;
      end
      ST_LOW: begin
        if (w_rise) begin
          hi_d = CNT_W'(1);
          lo_d = '0;
        end else if (!w_filt) begin
          lo_d = w_lo_inc;
          if (w_lo_hit) begin
            sv_d  = 1'b1;
            sym_d = SYM_ERR;
            los_d = 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (w_fall) begin
          hi_d  = '0;
          sv_d  = 1'b1;
          sym_d = w_class;
          if (w_class != SYM_ERR) los_d = 1'b0;
        end else if (w_filt) begin
          hi_d = w_hi_inc;
          if (w_hi_top) begin
            sv_d  = 1'b1;
            sym_d = SYM_ERR;
            los_d = 1'b1;
          end
        end
      end
      ST_STUCK_HI: begin
        if (w_fall) hi_d = '0;
      end
      default: begin
        hi_d = '0;
        lo_d = '0;
      end
    endcase
  end

  assign rise_stb  = w_rise;
  assign sym_valid = sv_q;
  assign sym       = sym_q;
  assign los       = los_q;

endmodule
`default_nettype wire

// File: tb/tb_irig_bit_classifier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_irig_bit_classifier
// Description : Directed bench for irig_bit_classifier with thresholds scaled
//               by 1/1000 (1 ms of IRIG time = 10 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irig_bit_classifier;

  localparam int FL = 4;
  localparam int D0 = 15, D1 = 35, MK = 65, HM = 95, LT = 120;
  localparam logic [1:0] S_D0 = 2'b00, S_D1 = 2'b01, S_MK = 2'b10, S_ER = 2'b11;

  logic       clk_10mhz = 1'b0;
  logic       rst = 1'b0;
  logic       irigb = 1'b0;
  logic       rise_stb, sym_valid, los;
  logic [1:0] sym;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state
  int         cyc = 0, raw_rise_cyc = 0, raw_fall_cyc = 0, last_rise_cyc = 0;
  int         rise_cnt = 0, sv_cnt = 0, rise_lat = 0, sv_lat = 0, sv_gap = 0;
  logic       irigb_prev = 1'b0;
  logic [1:0] last_sym = 2'b00;
  logic       last_los = 1'b0;

  irig_bit_classifier #(
    .FILTER_LEN (FL), .D0_MIN (D0), .D1_MIN (D1),
    .MK_MIN (MK), .HI_MAX (HM), .LO_TIMEOUT (LT)
  ) dut (
    .clk_10mhz (clk_10mhz),
    .rst       (rst),
    .irigb     (irigb),
    .rise_stb  (rise_stb),
    .sym_valid (sym_valid),
    .sym       (sym),
    .los       (los)
  );

  always #5 clk_10mhz = ~clk_10mhz;

  // Observe on the falling edge, away from the active edge
  always @(negedge clk_10mhz) begin
    cyc++;
    if (irigb && !irigb_prev) raw_rise_cyc = cyc;
    if (!irigb && irigb_prev) raw_fall_cyc = cyc;
    irigb_prev = irigb;
    if (rise_stb) begin
      rise_cnt++;
      rise_lat = cyc - raw_rise_cyc;
      last_rise_cyc = cyc;
    end
    if (sym_valid) begin
      sv_cnt++;
      last_sym = sym;
      last_los = los;
      sv_lat = cyc - raw_fall_cyc;
      sv_gap = cyc - last_rise_cyc;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Hold the line at v across n rising edges; changes land 2 ns after an edge
  task automatic drive(input logic v, input int n);
    irigb = v;
    repeat (n) begin
      @(posedge clk_10mhz);
      #2;
    end
  endtask

  typedef struct {
    int         hi;
    int         lo;
    logic [1:0] exp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         sv0, r0;
    logic       model_los;
    string      tag;

    // 10 ms-period frame (D0, MARK, D1) followed by the classification boundaries
    vecs[0] = '{20, 80, S_D0};
    vecs[1] = '{80, 20, S_MK};
    vecs[2] = '{50, 50, S_D1};
    vecs[3] = '{14, 60, S_ER};
    vecs[4] = '{15, 60, S_D0};
    vecs[5] = '{34, 60, S_D0};
    vecs[6] = '{35, 60, S_D1};
    vecs[7] = '{64, 60, S_D1};
    vecs[8] = '{65, 60, S_MK};
    vecs[9] = '{94, 60, S_MK};

    // Reset with line low
    repeat (3) @(posedge clk_10mhz);
    @(negedge clk_10mhz); #1;
    check("rst_sym", sym, S_ER);
    check("rst_los", los, 1);
    check("rst_sym_valid", sym_valid, 0);
    check("rst_rise_stb", rise_stb, 0);
    @(posedge clk_10mhz); #2;
    rst = 1'b1;
    drive(1'b0, 30);
    check("seek_fall_no_sym", sv_cnt, 0);
    check("seek_fall_no_rise", rise_cnt, 0);
    check("seek_los_held", los, 1);

    model_los = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sv0 = sv_cnt;
      r0  = rise_cnt;
      drive(1'b1, vecs[i].hi);
      drive(1'b0, vecs[i].lo);
      if (vecs[i].exp != S_ER) model_los = 1'b0;
      tag = $sformatf("v%0d_hi%0d", i, vecs[i].hi);
      check({tag, "_nsym"}, sv_cnt - sv0, 1);
      check({tag, "_nrise"}, rise_cnt - r0, 1);
      check({tag, "_sym"}, last_sym, vecs[i].exp);
      check({tag, "_los"}, last_los, model_los);
      check({tag, "_rise_lat"}, rise_lat, 2 + FL);
      check({tag, "_sv_lat"}, sv_lat, 3 + FL);
      check({tag, "_sym_hold"}, sym, vecs[i].exp);
    end

    // Stuck high: ERR when the high count reaches HI_MAX, nothing at the later fall
    sv0 = sv_cnt;
    drive(1'b1, 120);
    check("stuck_nsym", sv_cnt - sv0, 1);
    check("stuck_sym", last_sym, S_ER);
    check("stuck_los", last_los, 1);
    check("stuck_gap", sv_gap, HM);
    drive(1'b0, 60);
    check("stuck_fall_no_sym", sv_cnt - sv0, 1);
    check("stuck_los_held", los, 1);

    // D0 clears loss, then a long low raises exactly one ERR, then D1 recovers
    sv0 = sv_cnt;
    drive(1'b1, 20);
    drive(1'b0, 30);
    check("pre_to_sym", last_sym, S_D0);
    check("pre_to_los", los, 0);
    drive(1'b0, 150);
    check("timeout_nsym", sv_cnt - sv0, 2);
    check("timeout_sym", last_sym, S_ER);
    check("timeout_los", los, 1);
    drive(1'b1, 50);
    drive(1'b0, 50);
    check("post_to_nsym", sv_cnt - sv0, 3);
    check("post_to_sym", last_sym, S_D1);
    check("post_to_los", los, 0);

    // Three-cycle glitches in low and high phases
    sv0 = sv_cnt;
    r0  = rise_cnt;
    drive(1'b0, 20);
    drive(1'b1, 3);
    drive(1'b0, 20);
    check("glitch_lo_no_rise", rise_cnt - r0, 0);
    drive(1'b1, 25);
    drive(1'b0, 3);
    drive(1'b1, 22);
    drive(1'b0, 40);
    check("glitch_nrise", rise_cnt - r0, 1);
    check("glitch_nsym", sv_cnt - sv0, 1);
    check("glitch_sym", last_sym, S_D1);

    // Reset 3 ms into a MARK pulse, released 1 ms later
    sv0 = sv_cnt;
    r0  = rise_cnt;
    drive(1'b1, 30);
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk_10mhz);
      #2;
    end
    check("midrst_sym", sym, S_ER);
    check("midrst_los", los, 1);
    rst = 1'b1;
    drive(1'b1, 40);
    drive(1'b0, 50);
    check("midrst_no_sym", sv_cnt - sv0, 0);
    drive(1'b1, 20);
    drive(1'b0, 40);
    check("midrst_nsym", sv_cnt - sv0, 1);
    check("midrst_nrise", rise_cnt - r0, 2);
    check("midrst_d0_sym", last_sym, S_D0);
    check("midrst_d0_los", last_los, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
